// File: rtl/jaxa_link_status_irq.sv
// ---------------------------------------------------------------------------
// jaxa_link_status_irq
// Link-status input port for the SpaceWire/JAXA link-monitor subsystem.
// Synchronises WIDTH asynchronous status bits, latches selected edges into a
// write-1-to-clear capture register, drives a masked level IRQ and counts
// capture events. Avalon-MM slave with a 1-cycle registered read.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous reset, active-high
//   address    - word address: 0 DATA, 1 MASK, 2 COUNT, 3 CAPTURE
//   chipselect - slave select, qualifies writes
//   write_n    - active-low write strobe
//   writedata  - write data
//   in_port    - asynchronous link-status inputs
//   readdata   - registered read data
//   irq        - registered level interrupt
//
// Build option: define JAXA_LINKSTAT_DEBOUNCE_EN to insert a per-bit debounce
// filter (DEBOUNCE_CYC stable cycles) between the synchroniser and the
// edge detector / DATA register.
// ---------------------------------------------------------------------------
module jaxa_link_status_irq #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned EDGE_TYPE    = 0,
    parameter int unsigned DEBOUNCE_CYC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0]  ADDR_DATA    = 2'd0;
    localparam logic [1:0]  ADDR_MASK    = 2'd1;
    localparam logic [1:0]  ADDR_COUNT   = 2'd2;
    localparam logic [1:0]  ADDR_CAPTURE = 2'd3;
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

`ifdef JAXA_LINKSTAT_DEBOUNCE_EN
    // The filter delays the first valid level, so arming must cover it too.
    localparam int unsigned ARM_CYC = SYNC_STAGES + 1 + DEBOUNCE_CYC;
`else
    localparam int unsigned ARM_CYC = SYNC_STAGES + 1;
`endif
    localparam int unsigned ARM_W = $clog2(ARM_CYC + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync_out;
    logic [WIDTH-1:0]                  w_filt;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  r_mask;
    logic [WIDTH-1:0]                  r_capture;
    logic [15:0]                       r_count;
    logic [ARM_W-1:0]                  r_arm_cnt;
    logic [31:0]                       r_readdata;
    logic                              r_irq;

    logic                              w_armed;
    logic [WIDTH-1:0]                  w_rise;
    logic [WIDTH-1:0]                  w_fall;
    logic [WIDTH-1:0]                  w_ev;
    logic                              w_any_ev;
    logic                              w_wr;
    logic                              w_wr_mask;
    logic                              w_wr_count;
    logic [WIDTH-1:0]                  w_clr;
    logic [31:0]                       w_rd_mux;

    // Synchroniser chain; the top stage is the oldest sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef JAXA_LINKSTAT_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [WIDTH-1:0][DB_W-1:0] r_db_cnt;
    logic [WIDTH-1:0]           r_filt;

    // Per-bit filter: accept a new level only after DEBOUNCE_CYC consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_cnt <= '0;
            r_filt   <= '0;
        end else begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                if (w_sync_out[b] == r_filt[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (r_db_cnt[b] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    r_filt[b]   <= w_sync_out[b];
                    r_db_cnt[b] <= '0;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    logic [7:0] w_unused_deb;
    assign w_unused_deb = 8'(DEBOUNCE_CYC);
    assign w_filt       = w_sync_out;
`endif

    // Arm counter: hold off events until the synchroniser holds real samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + ARM_W'(1);
        end
    end

    assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYC));

    // Edge detection and event selection.
    always_comb begin
        w_rise = w_filt & ~r_prev;
        w_fall = ~w_filt & r_prev;
        w_ev   = '0;
        case (EDGE_TYPE)
            1:       w_ev = w_rise;
            2:       w_ev = w_fall;
            default: w_ev = w_rise | w_fall;
        endcase
        if (!w_armed) begin
            w_ev = '0;
        end
    end

    assign w_any_ev   = |w_ev;
    assign w_wr       = chipselect & ~write_n;
    assign w_wr_mask  = w_wr && (address == ADDR_MASK);
    assign w_wr_count = w_wr && (address == ADDR_COUNT);
    assign w_clr      = (w_wr && (address == ADDR_CAPTURE)) ? writedata[WIDTH-1:0] : '0;

    // Read mux; unused upper bits read as zero.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:    w_rd_mux = 32'(w_filt);
            ADDR_MASK:    w_rd_mux = 32'(r_mask);
            ADDR_COUNT:   w_rd_mux = 32'(r_count);
            ADDR_CAPTURE: w_rd_mux = 32'(r_capture);
            default:      w_rd_mux = '0;
        endcase
    end

    // Register file, capture, IRQ and event counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_mask     <= '0;
            r_capture  <= '0;
            r_count    <= '0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_prev <= w_filt;
            if (w_wr_mask) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            // Set wins over a simultaneous W1C clear.
            r_capture <= (r_capture & ~w_clr) | w_ev;
            r_irq     <= |(r_capture & r_mask);
            // Clear-then-count: a write coinciding with an event leaves 1.
            if (w_wr_count) begin
                r_count <= w_any_ev ? 16'd1 : 16'd0;
            end else if (w_any_ev && (r_count != CNT_MAX)) begin
                r_count <= r_count + 16'd1;
            end
            r_readdata <= w_rd_mux;
        end
    end

    generate
        if (WIDTH < 32) begin : g_wd_unused
            logic w_unused_wd;
            assign w_unused_wd = &{1'b0, writedata[31:WIDTH]};
        end
    endgenerate

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_jaxa_link_status_irq.sv
// Self-checking bench for jaxa_link_status_irq: directed scenarios plus a
// randomized run compared against a behavioural model of the register rules.
module tb_jaxa_link_status_irq;

    localparam int unsigned W   = 16;
    localparam int unsigned S   = 2;
    localparam int unsigned ET  = 0;
    localparam int unsigned DEB = 8;
`ifdef JAXA_LINKSTAT_DEBOUNCE_EN
    localparam int unsigned FLAT = DEB;
`else
    localparam int unsigned FLAT = 0;
`endif
    localparam int unsigned ARM = S + 1 + FLAT;
    localparam int unsigned LAT = S + FLAT;

    logic          clk;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;
    logic [31:0]   readdata_r;
    logic          irq_r;

    int checks   = 0;
    int failures = 0;

    jaxa_link_status_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(ET), .DEBOUNCE_CYC(DEB)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    // Rising-edge-only variant sharing the same stimulus.
    jaxa_link_status_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(1), .DEBOUNCE_CYC(DEB)) dut_r (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_r), .irq(irq_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: input delay line, filtered level, registers.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_data, m_prev, m_mask, m_cap;
    int           m_run[W];
    int unsigned  m_arm;
    int unsigned  m_cnt;
    logic         m_irq;
    logic [31:0]  m_rd;

    function automatic void model_step();
        logic [W-1:0] sync_now, rise, fall, ev, clr;
        logic         wr;
        if (reset) begin
            m_hist = {};
            for (int i = 0; i < int'(S); i++) m_hist.push_back('0);
            m_data = '0; m_prev = '0; m_mask = '0; m_cap = '0;
            for (int b = 0; b < int'(W); b++) m_run[b] = 0;
            m_arm = 0; m_cnt = 0; m_irq = 1'b0; m_rd = '0;
            return;
        end
        sync_now = m_hist[0];
        rise = m_data & ~m_prev;
        fall = ~m_data & m_prev;
        case (ET)
            1:       ev = rise;
            2:       ev = fall;
            default: ev = rise | fall;
        endcase
        if (m_arm < ARM) ev = '0;
        wr = chipselect && !write_n;
        case (address)
            2'd0:    m_rd = 32'(m_data);
            2'd1:    m_rd = 32'(m_mask);
            2'd2:    m_rd = m_cnt;
            default: m_rd = 32'(m_cap);
        endcase
        m_irq = |(m_cap & m_mask);
        clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | ev;
        if (wr && address == 2'd2)            m_cnt = (ev != '0) ? 1 : 0;
        else if (ev != '0 && m_cnt < 65535)   m_cnt = m_cnt + 1;
        if (wr && address == 2'd1) m_mask = writedata[W-1:0];
        m_prev = m_data;
        void'(m_hist.pop_front());
        m_hist.push_back(in_port);
`ifdef JAXA_LINKSTAT_DEBOUNCE_EN
        for (int b = 0; b < int'(W); b++) begin
            if (sync_now[b] != m_data[b]) begin
                m_run[b]++;
                if (m_run[b] == int'(DEB)) begin
                    m_data[b] = sync_now[b];
                    m_run[b]  = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
`else
        m_data = m_hist[0];
`endif
        if (m_arm < ARM) m_arm++;
    endfunction

    // One clock: advance the model with the inputs seen at this edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] v);
        address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] dr);
        address = a; chipselect = 1'b0; write_n = 1'b1;
        tick();
        d  = readdata;
        dr = readdata_r;
    endtask

    task automatic apply_reset(input logic [W-1:0] v);
        reset = 1'b1; in_port = v; chipselect = 1'b0; write_n = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (ARM + 2) tick();
    endtask

    task automatic test_reset();
        logic [31:0] d, dr;
        reset = 1'b1; in_port = '1; chipselect = 1'b0; write_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (readdata !== 32'h0) begin failures++; $display("FAIL rst_readdata: got %h expected %h", readdata, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b expected 0", irq); end
        reset = 1'b0;
        repeat (ARM + 4) tick();
        do_read(2'd0, d, dr);
        checks++;
        if (d !== 32'h0000FFFF) begin failures++; $display("FAIL t1_data: got %h expected %h", d, 32'h0000FFFF); end
        do_read(2'd3, d, dr);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL t1_capture: got %h expected %h", d, 32'h0); end
        do_read(2'd2, d, dr);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL t1_count: got %h expected %h", d, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL t1_irq: got %b expected 0", irq); end
    endtask

    task automatic test_rise_irq();
        logic [31:0] d, dr;
        int  lat;
        bit  seen;
        apply_reset('0);
        do_write(2'd1, 32'h1);
        in_port[0] = 1'b1;
        lat = 0; seen = 0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            tick();
            if (irq === 1'b1) begin seen = 1; lat = n; end
        end
        checks++;
        if (!seen || lat != int'(LAT + 2))
            begin failures++; $display("FAIL t2_irq_latency: got %0d (seen=%0d) expected %0d", lat, seen, LAT + 2); end
        do_read(2'd3, d, dr);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL t2_capture: got %h expected %h", d, 32'h1); end
        do_read(2'd2, d, dr);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL t2_count: got %h expected %h", d, 32'h1); end
    endtask

    task automatic test_w1c();
        logic [31:0] d, dr;
        do_write(2'd3, 32'h1);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL t3_irq_hold: got %b expected 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL t3_irq_fall: got %b expected 0", irq); end
        do_read(2'd3, d, dr);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL t3_cleared: got %h expected %h", d, 32'h0); end
        // Falling edge of bit 0 lands on the same edge as the clear.
        in_port[0] = 1'b0;
        repeat (LAT) tick();
        do_write(2'd3, 32'h1);
        do_read(2'd3, d, dr);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL t3_set_wins: got %h expected %h", d, 32'h1); end
    endtask

    task automatic test_edge_type();
        logic [31:0] d, dr;
        apply_reset('0);
        in_port[3] = 1'b1;
        repeat (LAT + 3) tick();
        in_port[3] = 1'b0;
        repeat (LAT + 3) tick();
        do_read(2'd3, d, dr);
        checks++;
        if (dr !== 32'h8) begin failures++; $display("FAIL t4_rise_capture: got %h expected %h", dr, 32'h8); end
        checks++;
        if (d !== 32'h8) begin failures++; $display("FAIL t4_any_capture: got %h expected %h", d, 32'h8); end
        do_read(2'd2, d, dr);
        checks++;
        if (dr !== 32'h1) begin failures++; $display("FAIL t4_rise_count: got %h expected %h", dr, 32'h1); end
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL t4_any_count: got %h expected %h", d, 32'h2); end
    endtask

`ifndef JAXA_LINKSTAT_DEBOUNCE_EN
    task automatic test_saturate();
        logic [31:0] d, dr;
        apply_reset('0);
        for (int i = 0; i < 65540; i++) begin
            in_port[0] = ~in_port[0];
            tick();
        end
        repeat (LAT + 1) tick();
        do_read(2'd2, d, dr);
        checks++;
        if (d !== 32'h0000FFFF) begin failures++; $display("FAIL t5_saturate: got %h expected %h", d, 32'h0000FFFF); end
        in_port[0] = ~in_port[0];
        repeat (LAT) tick();
        do_write(2'd2, 32'h0);
        do_read(2'd2, d, dr);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL t5_clear_then_count: got %h expected %h", d, 32'h1); end
    endtask
`else
    task automatic test_debounce();
        logic [31:0] d, dr;
        apply_reset('0);
        in_port[5] = 1'b1;
        repeat (DEB / 2 + 1) tick();
        in_port[5] = 1'b0;
        repeat (LAT + DEB + 4) tick();
        do_read(2'd3, d, dr);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL t6_short_capture: got %h expected %h", d, 32'h0); end
        do_read(2'd0, d, dr);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL t6_short_data: got %h expected %h", d, 32'h0); end
        in_port[5] = 1'b1;
        repeat (DEB) tick();
        in_port[5] = 1'b0;
        repeat (LAT + DEB + 4) tick();
        do_read(2'd3, d, dr);
        checks++;
        if (d !== 32'h20) begin failures++; $display("FAIL t6_long_capture: got %h expected %h", d, 32'h20); end
    endtask
`endif

    task automatic test_random();
        apply_reset(W'($urandom));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            if (i == 700) reset = 1'b1;
            if (i == 703) reset = 1'b0;
            tick();
            checks++;
            if (readdata !== m_rd)
                begin failures++; $display("FAIL rand_readdata[%0d]: got %h expected %h", i, readdata, m_rd); end
            checks++;
            if (irq !== m_irq)
                begin failures++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_irq); end
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        test_reset();
        test_rise_irq();
        test_w1c();
        test_edge_type();
`ifndef JAXA_LINKSTAT_DEBOUNCE_EN
        test_saturate();
`else
        test_debounce();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
